// File: rtl/bldc_pkg.sv
// bldc_pkg: shared drive encodings, hall table, direction type and vector decoder
package bldc_pkg;
  localparam logic [1:0] HI = 2'b10, LO = 2'b01, FLOAT = 2'b00, SHOOT = 2'b11;
  localparam logic [2:0] HALL_TABLE [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  typedef enum logic [1:0] {NONE, FWD, REV} dir_t;
  typedef struct packed {
    logic       valid;
    logic [2:0] target;
  } vec_t;
  function automatic vec_t vec_to_target(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    logic [2:0] hi, lo, fl;
    vec_t v;
    hi = {c == HI, b == HI, a == HI};
    lo = {c == LO, b == LO, a == LO};
    fl = {c == FLOAT, b == FLOAT, a == FLOAT};
    v.valid = $onehot(hi) && $onehot(lo) && $onehot(fl);
    case ({hi, lo})
      6'b001_010: v.target = 3'd1;
      6'b001_100: v.target = 3'd2;
      6'b010_100: v.target = 3'd3;
      6'b010_001: v.target = 3'd4;
      6'b100_001: v.target = 3'd5;
      default:    v.target = 3'd0;
    endcase
    return v;
  endfunction
endpackage

// File: rtl/bldc_hall_emulator_pwm_duty_meter.sv
// pwm_duty_meter: counts on-cycles per fixed window and latches the total at window end
module pwm_duty_meter #(
  parameter int WIN_LEN = 16,
  parameter int DW      = $clog2(WIN_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_on,
  output logic [DW-1:0] o_duty
);
  logic [DW-1:0] r_win, r_on;
  always_ff @(posedge clk)
    if (rst) begin
      r_win  <= '0;
      r_on   <= '0;
      o_duty <= '0;
    end else if (r_win == DW'(WIN_LEN - 1)) begin
      r_win  <= '0;
      r_on   <= '0;
      o_duty <= r_on + DW'(i_on);
    end else begin
      r_win <= r_win + DW'(1);
      r_on  <= r_on + DW'(i_on);
    end
endmodule

// File: rtl/bldc_hall_emulator.sv
// bldc_hall_emulator: hall-sensor rotor model for six-step drive bring-up; BLDC_STALL_DETECT_EN adds STALL
module bldc_hall_emulator
  import bldc_pkg::*;
#(
  parameter int WIN_LEN     = 16,
  parameter int STEP_THRESH = 256,
  parameter int ACC_W       = 12,
  parameter int INIT_POS    = 0
`ifdef BLDC_STALL_DETECT_EN
  , parameter int STALL_CYCLES = 1024
`endif
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [1:0]                     A,
  input  logic [1:0]                     B,
  input  logic [1:0]                     C,
  output logic [2:0]                     H,
  output logic                           DIR,
  output logic                           FAULT,
  output logic [$clog2(WIN_LEN+1)-1:0]   DUTY
`ifdef BLDC_STALL_DETECT_EN
  , output logic                         STALL
`endif
);
  localparam int DW = $clog2(WIN_LEN + 1);
  logic [2:0]       r_pos, r_h;
  logic             r_dir, r_fault;
  logic [ACC_W-1:0] r_acc;
  dir_t             r_dir_q;
  vec_t             w_vec;
  logic             w_shoot, w_acc_en, w_step;
  logic [ACC_W-1:0] w_sum;
  logic [2:0]       w_fwd, w_rev, w_pos_nxt;
  dir_t             w_dir_new;
  pwm_duty_meter #(.WIN_LEN(WIN_LEN), .DW(DW)) u_duty (
    .clk(CLK), .rst(RST), .i_on(w_vec.valid), .o_duty(DUTY)
  );
  assign w_vec     = vec_to_target(A, B, C);
  assign w_shoot   = (A == SHOOT) || (B == SHOOT) || (C == SHOOT);
  assign w_fwd     = (r_pos == 3'd5) ? 3'd0 : r_pos + 3'd1;
  assign w_rev     = (r_pos == 3'd0) ? 3'd5 : r_pos - 3'd1;
  assign w_dir_new = (w_vec.target == w_fwd) ? FWD : (w_vec.target == w_rev) ? REV : NONE;
  assign w_sum     = r_acc + ACC_W'(DUTY);
  // a shoot-through input blocks the step on the very cycle it appears, before FAULT registers
  assign w_acc_en  = !r_fault && !w_shoot && (r_dir_q != NONE);
  assign w_step    = w_acc_en && (w_sum >= ACC_W'(STEP_THRESH));
  assign w_pos_nxt = (r_dir_q == FWD) ? w_fwd : w_rev;
  always_ff @(posedge CLK)
    if (RST) begin
      r_pos   <= 3'(INIT_POS);
      r_h     <= HALL_TABLE[INIT_POS];
      r_dir   <= 1'b1;
      r_fault <= 1'b0;
      r_acc   <= '0;
      r_dir_q <= NONE;
    end else begin
      if (w_shoot) r_fault <= 1'b1;
      if (w_step) begin
        r_acc   <= w_sum - ACC_W'(STEP_THRESH);
        r_pos   <= w_pos_nxt;
        r_h     <= HALL_TABLE[w_pos_nxt];
        r_dir   <= (r_dir_q == FWD);
        r_dir_q <= NONE;
      end else begin
        if (w_acc_en) r_acc <= w_sum;
        if (w_vec.valid) r_dir_q <= w_dir_new;
      end
    end
  assign H     = r_h;
  assign DIR   = r_dir;
  assign FAULT = r_fault;
`ifdef BLDC_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYCLES + 1);
  logic [SW-1:0] r_stall_cnt;
  logic          r_stall;
  always_ff @(posedge CLK)
    if (RST || w_step) begin
      r_stall_cnt <= '0;
      r_stall     <= 1'b0;
    end else if (r_dir_q == NONE) r_stall_cnt <= '0;
    else begin
      if (r_stall_cnt != SW'(STALL_CYCLES)) r_stall_cnt <= r_stall_cnt + SW'(1);
      if (r_stall_cnt >= SW'(STALL_CYCLES - 1)) r_stall <= 1'b1;
    end
  assign STALL = r_stall;
`endif
endmodule
